// File: rtl/video_timing_pkg.sv
// Raster timing constants for 720p60, shared by the timing generator and by
// sprite/overlay modules that need the visible screen bounds.
package video_timing_pkg;

  // Counter widths of the raster position and frame count outputs.
  localparam int HCOUNT_W = 11;
  localparam int VCOUNT_W = 10;
  localparam int FC_W     = 6;

  // 720p60 horizontal timing, in pixels.
  localparam int ACTIVE_H_720      = 1280;
  localparam int H_FRONT_PORCH_720 = 110;
  localparam int H_SYNC_WIDTH_720  = 40;
  localparam int H_BACK_PORCH_720  = 220;

  // 720p60 vertical timing, in lines.
  localparam int ACTIVE_V_720      = 720;
  localparam int V_FRONT_PORCH_720 = 5;
  localparam int V_SYNC_WIDTH_720  = 5;
  localparam int V_BACK_PORCH_720  = 20;

  localparam int FPS_720 = 60;

  // Derived totals and sync windows (inclusive start/end positions).
  localparam int H_TOTAL_720 = ACTIVE_H_720 + H_FRONT_PORCH_720 + H_SYNC_WIDTH_720 + H_BACK_PORCH_720;
  localparam int V_TOTAL_720 = ACTIVE_V_720 + V_FRONT_PORCH_720 + V_SYNC_WIDTH_720 + V_BACK_PORCH_720;
  localparam int HS_START_720 = ACTIVE_H_720 + H_FRONT_PORCH_720;
  localparam int HS_END_720   = HS_START_720 + H_SYNC_WIDTH_720 - 1;
  localparam int VS_START_720 = ACTIVE_V_720 + V_FRONT_PORCH_720;
  localparam int VS_END_720   = VS_START_720 + V_SYNC_WIDTH_720 - 1;

endpackage

// File: rtl/video_sig_gen_wrap_counter.sv
// Modulo-MAX counter with enable and synchronous active-low reset.
// Exposes the registered value, the value it will take at the next edge,
// and a wrap pulse that is high while the counter is about to roll over.
module wrap_counter #(
  parameter int MAX   = 2,
  parameter int WIDTH = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] value_o,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MAX - 1);

  logic [WIDTH-1:0] value_q;
  logic [WIDTH-1:0] value_d;

  // Next value: hold when disabled, roll over to zero after LAST.
  always_comb begin
    value_d = value_q;
    if (en_i) begin
      if (value_q == LAST) begin
        value_d = '0;
      end else begin
        value_d = value_q + 1'b1;
      end
    end
  end

  assign wrap_o  = en_i && (value_q == LAST);
  assign next_o  = value_d;
  assign value_o = value_q;

  // Count register, cleared while reset is held.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      value_q <= '0;
    end else begin
      value_q <= value_d;
    end
  end

endmodule

// File: rtl/video_sig_gen.sv
// Raster timing generator: pixel coordinates, sync pulses, active-draw flag,
// new-frame strobe and frame count. One pixel per clock.
// Every flag is decoded from the counters' next values and registered, so the
// flags line up with the hcount/vcount shown in the same cycle.
module video_sig_gen
  import video_timing_pkg::*;
#(
  parameter int ACTIVE_H      = ACTIVE_H_720,
  parameter int H_FRONT_PORCH = H_FRONT_PORCH_720,
  parameter int H_SYNC_WIDTH  = H_SYNC_WIDTH_720,
  parameter int H_BACK_PORCH  = H_BACK_PORCH_720,
  parameter int ACTIVE_V      = ACTIVE_V_720,
  parameter int V_FRONT_PORCH = V_FRONT_PORCH_720,
  parameter int V_SYNC_WIDTH  = V_SYNC_WIDTH_720,
  parameter int V_BACK_PORCH  = V_BACK_PORCH_720,
  parameter int FPS           = FPS_720
) (
  input  logic                clk_in,
  input  logic                rst_in,
  output logic [HCOUNT_W-1:0] hcount_out,
  output logic [VCOUNT_W-1:0] vcount_out,
  output logic                hs_out,
  output logic                vs_out,
  output logic                ad_out,
  output logic                nf_out,
  output logic [FC_W-1:0]     fc_out
);

  localparam int H_TOTAL = ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int V_TOTAL = ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  // Full-width decode thresholds.
  localparam logic [HCOUNT_W-1:0] ACT_H_C    = HCOUNT_W'(ACTIVE_H);
  localparam logic [VCOUNT_W-1:0] ACT_V_C    = VCOUNT_W'(ACTIVE_V);
  localparam logic [HCOUNT_W-1:0] HS_START_C = HCOUNT_W'(ACTIVE_H + H_FRONT_PORCH);
  localparam logic [HCOUNT_W-1:0] HS_END_C   = HCOUNT_W'(ACTIVE_H + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [VCOUNT_W-1:0] VS_START_C = VCOUNT_W'(ACTIVE_V + V_FRONT_PORCH);
  localparam logic [VCOUNT_W-1:0] VS_END_C   = VCOUNT_W'(ACTIVE_V + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

  // A parameter set that overflows the fixed output widths is unusable.
  if (H_TOTAL > 2048 || V_TOTAL > 1024 || FPS > 64 || FPS < 1 ||
      H_SYNC_WIDTH < 1 || V_SYNC_WIDTH < 1) begin : g_bad_params
    $error("video_sig_gen: timing parameters do not fit the counter widths");
  end

  logic [HCOUNT_W-1:0] h_val, h_next;
  logic [VCOUNT_W-1:0] v_val, v_next;
  logic [FC_W-1:0]     f_val, f_next;
  logic                h_wrap, v_wrap, f_wrap;
  logic                unused_wraps;

  logic hs_d, vs_d, ad_d, nf_d;
  logic hs_q, vs_q, ad_q, nf_q;

  wrap_counter #(.MAX(H_TOTAL), .WIDTH(HCOUNT_W)) u_hcount (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .en_i    (1'b1),
    .value_o (h_val),
    .next_o  (h_next),
    .wrap_o  (h_wrap)
  );

  wrap_counter #(.MAX(V_TOTAL), .WIDTH(VCOUNT_W)) u_vcount (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .en_i    (h_wrap),
    .value_o (v_val),
    .next_o  (v_next),
    .wrap_o  (v_wrap)
  );

  // Frame count advances on the same edge that raises nf_out.
  wrap_counter #(.MAX(FPS), .WIDTH(FC_W)) u_fcount (
    .clk_i   (clk_in),
    .rst_n_i (rst_in),
    .en_i    (nf_d),
    .value_o (f_val),
    .next_o  (f_next),
    .wrap_o  (f_wrap)
  );

  // Only the line wrap drives anything; the others are informational.
  assign unused_wraps = v_wrap ^ f_wrap ^ (^f_next);

  // Decode the flags for the position the counters are about to show.
  always_comb begin
    hs_d = (h_next >= HS_START_C) && (h_next <= HS_END_C);
    vs_d = (v_next >= VS_START_C) && (v_next <= VS_END_C);
    ad_d = (h_next < ACT_H_C) && (v_next < ACT_V_C);
    nf_d = (h_next == ACT_H_C) && (v_next == ACT_V_C);
  end

  // Flag registers, cleared while reset is held.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      ad_q <= 1'b0;
      nf_q <= 1'b0;
    end else begin
      hs_q <= hs_d;
      vs_q <= vs_d;
      ad_q <= ad_d;
      nf_q <= nf_d;
    end
  end

  assign hcount_out = h_val;
  assign vcount_out = v_val;
  assign fc_out     = f_val;
  assign hs_out     = hs_q;
  assign vs_out     = vs_q;
  assign ad_out     = ad_q;
  assign nf_out     = nf_q;

endmodule
